// File: rtl/dac_sample_scheduler.sv
// Paces stereo samples from a small FIFO into a serial DAC writer at a programmable tick rate.
// Define DAC_SCHED_MIDSCALE_EN to send 16'h8000 on underrun instead of repeating the last words.
module dac_sample_scheduler #(
   parameter int DIV_WIDTH = 16,
   parameter int FIFO_AW   = 2,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [DIV_WIDTH-1:0] rate_div,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [15:0]          in_data_a,
   input  logic [15:0]          in_data_b,
   output logic                 dac_start,
   input  logic                 dac_ready,
   output logic [15:0]          dac_data_a,
   output logic [15:0]          dac_data_b,
   output logic [FIFO_AW:0]     fifo_level,
   output logic [CNT_WIDTH-1:0] underrun_cnt,
   output logic [CNT_WIDTH-1:0] late_cnt,
   output logic                 active
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW:0] LVL_ONE  = (FIFO_AW+1)'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

   state_t                 state_q, state_d;
   logic [DIV_WIDTH-1:0]   div_q, div_d;
   logic                   pending_q, pending_d;
   logic [FIFO_AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]       level_q, level_d;
   logic [15:0]            data_a_q, data_a_d, data_b_q, data_b_d;
   logic [CNT_WIDTH-1:0]   underrun_q, underrun_d, late_q, late_d;
   logic [15:0]            mem_a_q [DEPTH];
   logic [15:0]            mem_b_q [DEPTH];

   logic tick, consume, fifo_empty, fifo_full, push, pop;

   assign tick       = enable && (div_q == rate_div);
   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == LVL_FULL);
   assign push       = in_valid && !fifo_full;
   // Emptiness is judged before this cycle's push, so a sample never bypasses the FIFO.
   assign consume    = (state_q == IDLE) && pending_q && dac_ready && enable;
   assign pop        = consume && !fifo_empty;

   assign in_ready     = !fifo_full;
   assign fifo_level   = level_q;
   assign dac_data_a   = data_a_q;
   assign dac_data_b   = data_b_q;
   assign underrun_cnt = underrun_q;
   assign late_cnt     = late_q;
   assign active       = (state_q != IDLE);

   // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      div_d      = '0;
      pending_d  = 1'b0;
      late_d     = late_q;
      underrun_d = underrun_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      data_a_d   = data_a_q;
      data_b_d   = data_b_q;

      if (enable) begin
         div_d     = tick ? '0 : div_q + DIV_WIDTH'(1);
         pending_d = tick || (pending_q && !consume);
      end
      if (tick && pending_q && !consume && (late_q != '1)) begin
         late_d = late_q + CNT_WIDTH'(1);
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      end
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase

      if (pop) begin
         rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
         data_a_d = mem_a_q[rd_ptr_q];
         data_b_d = mem_b_q[rd_ptr_q];
      end else if (consume) begin
         if (underrun_q != '1) begin
            underrun_d = underrun_q + CNT_WIDTH'(1);
         end
`ifdef DAC_SCHED_MIDSCALE_EN
         data_a_d = 16'h8000;
         data_b_d = 16'h8000;
`else
         data_a_d = data_a_q;
         data_b_d = data_b_q;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      dac_start = 1'b0;
      case (state_q)
         IDLE:      if (consume) state_d = ISSUE;
         ISSUE: begin
            dac_start = 1'b1;
            state_d   = WAIT_ACK;
         end
         WAIT_ACK:  if (!dac_ready) state_d = WAIT_DONE;
         WAIT_DONE: if (dac_ready) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         div_q      <= '0;
         pending_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         data_a_q   <= '0;
         data_b_q   <= '0;
         underrun_q <= '0;
         late_q     <= '0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         pending_q  <= pending_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         data_a_q   <= data_a_d;
         data_b_q   <= data_b_d;
         underrun_q <= underrun_d;
         late_q     <= late_d;
      end
   end

   // NOTE: the storage array is not reset; the pointers and level alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a_q[wr_ptr_q] <= in_data_a;
         mem_b_q[wr_ptr_q] <= in_data_b;
      end
   end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Randomized bench for dac_sample_scheduler: a tick/transfer-level reference model feeds a
// scoreboard of expected DAC issues that a monitor checks against every dac_start.
module tb_dac_sample_scheduler;

   localparam int DIV_WIDTH = 16;
   localparam int FIFO_AW   = 2;
   localparam int CNT_WIDTH = 8;
`ifdef DAC_SCHED_MIDSCALE_EN
   localparam bit MIDSCALE = 1'b1;
`else
   localparam bit MIDSCALE = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 reset, enable, in_valid, dac_ready;
   logic [DIV_WIDTH-1:0] rate_div;
   logic [15:0]          in_data_a, in_data_b;
   logic                 in_ready, dac_start, active;
   logic [15:0]          dac_data_a, dac_data_b;
   logic [FIFO_AW:0]     fifo_level;
   logic [CNT_WIDTH-1:0] underrun_cnt, late_cnt;

   dac_sample_scheduler #(.DIV_WIDTH(DIV_WIDTH), .FIFO_AW(FIFO_AW), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk(clk), .reset(reset), .enable(enable), .rate_div(rate_div),
      .in_valid(in_valid), .in_ready(in_ready), .in_data_a(in_data_a), .in_data_b(in_data_b),
      .dac_start(dac_start), .dac_ready(dac_ready), .dac_data_a(dac_data_a), .dac_data_b(dac_data_b),
      .fifo_level(fifo_level), .underrun_cnt(underrun_cnt), .late_cnt(late_cnt), .active(active)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   // Writer model: drops ready the cycle after a start and stays busy for wr_busy cycles.
   int wr_busy = 10;
   initial begin
      int   left;
      logic s, r;
      dac_ready = 1'b1;
      left      = 0;
      forever begin
         @(negedge clk);
         s = dac_start;
         r = reset;
         @(posedge clk); #1;
         if (r) begin
            left      = 0;
            dac_ready = 1'b1;
         end else if (s) begin
            left      = wr_busy;
            dac_ready = 1'b0;
         end else if (left > 1) begin
            left--;
         end else begin
            left      = 0;
            dac_ready = 1'b1;
         end
      end
   end

   // Reference model: ticks from arithmetic on the enable start cycle, a sample queue,
   // and a busy flag covering a transfer until the writer has dropped and raised ready.
   typedef struct {logic [15:0] a; logic [15:0] b;} sample_t;
   typedef struct {logic [15:0] a; logic [15:0] b; int cyc;} issue_t;

   sample_t     mq[$];
   issue_t      exp_q[$];
   bit          m_pend, m_busy, m_first, m_low, prev_run;
   int          en_start, m_under, m_late;
   logic [15:0] m_a, m_b;

   always @(negedge clk) begin
      bit      tick, consume, exp_start, accept;
      issue_t  e;
      sample_t s;
      if (reset) begin
         mq.delete();
         exp_q.delete();
         m_pend = 0; m_busy = 0; m_first = 0; m_low = 0; prev_run = 0;
         m_under = 0; m_late = 0; m_a = '0; m_b = '0;
      end else begin
         check("fifo_level", fifo_level, mq.size());
         check("in_ready", in_ready, mq.size() < 4);
         check("active", active, m_busy);
         check("dac_data_a", dac_data_a, m_a);
         check("dac_data_b", dac_data_b, m_b);
         check("underrun_cnt", underrun_cnt, m_under);
         check("late_cnt", late_cnt, m_late);

         exp_start = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
         if (exp_start || dac_start) begin
            check("dac_start", dac_start, exp_start);
            if (exp_start) begin
               e = exp_q.pop_front();
               check("issue_a", dac_data_a, e.a);
               check("issue_b", dac_data_b, e.b);
            end
         end

         accept = in_valid && (mq.size() < 4);
         if (enable && !prev_run) en_start = cyc;
         tick    = enable && (((cyc - en_start) % (int'(rate_div) + 1)) == int'(rate_div));
         consume = !m_busy && m_pend && dac_ready && enable;
         if (tick && m_pend && !consume && m_late < 255) m_late++;
         m_pend = enable && (tick || (m_pend && !consume));

         if (consume) begin
            if (mq.size() > 0) begin
               s   = mq.pop_front();
               m_a = s.a;
               m_b = s.b;
            end else begin
               if (m_under < 255) m_under++;
               if (MIDSCALE) begin
                  m_a = 16'h8000;
                  m_b = 16'h8000;
               end
            end
            exp_q.push_back('{a: m_a, b: m_b, cyc: cyc + 1});
            m_busy = 1; m_first = 1; m_low = 0;
         end else if (m_busy) begin
            if (m_first)         m_first = 0;
            else if (!m_low)     m_low = !dac_ready;
            else if (dac_ready)  m_busy = 0;
         end

         if (accept) mq.push_back('{a: in_data_a, b: in_data_b});
         prev_run = enable;
      end
   end

   task automatic check_reset_state(input string tag);
      check({tag, "_start"}, dac_start, 0);
      check({tag, "_active"}, active, 0);
      check({tag, "_level"}, fifo_level, 0);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_data_a"}, dac_data_a, 0);
      check({tag, "_data_b"}, dac_data_b, 0);
      check({tag, "_underrun"}, underrun_cnt, 0);
      check({tag, "_late"}, late_cnt, 0);
   endtask

   initial begin
      int  e_cyc, first_start;
      bit  accepted, found;
      reset = 1'b1; enable = 1'b0; rate_div = '0;
      in_valid = 1'b0; in_data_a = '0; in_data_b = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_state("por");

      // Prefill four samples, then hold a fifth against a full FIFO while ticking at 100 cycles.
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         in_valid  = 1'b1;
         in_data_a = 16'(16'h1000 + i);
         in_data_b = 16'(16'h2000 + i);
         @(posedge clk); #1;
      end
      in_data_a = 16'h1004;
      in_data_b = 16'h2004;
      rate_div  = 16'd99;
      wr_busy   = 60;
      enable    = 1'b1;
      e_cyc     = cyc;
      @(negedge clk);
      check("full_in_ready", in_ready, 0);
      check("full_level", fifo_level, 4);
      first_start = -1;
      accepted    = 1'b0;
      for (int k = 0; k < 300 && (first_start < 0 || !accepted); k++) begin
         if (first_start < 0 && dac_start) first_start = cyc;
         if (in_valid && in_ready) accepted = 1'b1;
         @(posedge clk); #1;
         if (accepted) in_valid = 1'b0;
         @(negedge clk);
      end
      check("first_start_cycle", first_start, e_cyc + 101);
      check("fifth_accepted", accepted, 1);
      while (cyc < e_cyc + 760) @(negedge clk);
      check("p1_underruns", underrun_cnt, 2);
      check("p1_late", late_cnt, 0);
      check("p1_last_a", dac_data_a, MIDSCALE ? 16'h8000 : 16'h1004);
      check("p1_last_b", dac_data_b, MIDSCALE ? 16'h8000 : 16'h2004);

      // Random rates, writer latencies and push patterns.
      @(posedge clk); #1;
      for (int blk = 0; blk < 6; blk++) begin
         enable   = 1'b0;
         rate_div = 16'($urandom_range(0, 30));
         wr_busy  = $urandom_range(1, 20);
         @(posedge clk); #1;
         enable = 1'b1;
         repeat (250) begin
            in_valid  = ($urandom_range(0, 2) == 0);
            in_data_a = 16'($urandom);
            in_data_b = 16'($urandom);
            @(posedge clk); #1;
         end
      end

      // Fast ticks against a slow writer drive late_cnt into saturation.
      in_valid = 1'b0;
      enable   = 1'b0;
      rate_div = 16'd9;
      wr_busy  = 50;
      @(posedge clk); #1;
      enable = 1'b1;
      repeat (5000) @(posedge clk);
      @(negedge clk);
      check("late_saturated", late_cnt, 255);

      // Reset in the middle of a transfer.
      @(posedge clk); #1;
      enable = 1'b0;
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_data_a = 16'h5A5A;
      in_data_b = 16'hA5A5;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rate_div = 16'd20;
      wr_busy  = 30;
      enable   = 1'b1;
      found    = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clk);
         if (active && !dac_ready) found = 1'b1;
      end
      check("reached_wait_done", found, 1);
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset  = 1'b0;
      enable = 1'b0;
      @(negedge clk);
      check_reset_state("mid_xfer");

      // rate_div=0: tick in the first enabled cycle, start two cycles later.
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_data_a = 16'hABCD;
      in_data_b = 16'h1234;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rate_div = '0;
      wr_busy  = 4;
      enable   = 1'b1;
      e_cyc    = cyc;
      first_start = -1;
      for (int k = 0; k < 20 && first_start < 0; k++) begin
         @(negedge clk);
         if (dac_start) first_start = cyc;
      end
      check("div0_start_cycle", first_start, e_cyc + 2);
      check("div0_data_a", dac_data_a, 16'hABCD);
      check("div0_data_b", dac_data_b, 16'h1234);
      repeat (100) @(posedge clk);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
